// File: rtl/print_status_rx.sv
// 8N1 UART receiver for the printer return line, single-entry valid/ready output.
// Optional PRINT_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point.
module print_status_rx #(
   parameter int BAUD_NUM = 2604,
   parameter int HALF_NUM = BAUD_NUM / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       data_ready,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(BAUD_NUM + 1);
   localparam logic [CW-1:0] BAUD_C = CW'(BAUD_NUM);
   localparam logic [CW-1:0] HALF_C = CW'(HALF_NUM);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t        state_q, state_d;
   logic          rx_m, rx_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          bit_val;
   logic          deliver;
   logic          ferr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

`ifdef PRINT_RX_MAJORITY_EN
   // Counter advances every cycle, so the last two rx_s values are S-1 and S-2.
   logic [1:0] hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist_q <= 2'b11;
      else     hist_q <= {hist_q[0], rx_s};
   end

   assign bit_val = (hist_q[0] & hist_q[1]) |
                    (hist_q[0] & rx_s) |
                    (hist_q[1] & rx_s);
`else
   assign bit_val = rx_s;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      deliver = 1'b0;
      ferr    = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_C) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = bit_val ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BAUD_C) begin
               cnt_d = '0;
               sh_d  = {bit_val, sh_q[7:1]};
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == BAUD_C) begin
               cnt_d = '0;
               if (bit_val) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A byte may land in the same cycle the consumer drains the old one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= ferr;
         overrun   <= deliver & data_valid & ~data_ready;
         if (deliver && (!data_valid || data_ready)) begin
            data       <= sh_q;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_print_status_rx.sv
// Directed bench for print_status_rx using a shortened bit period.
// Table-driven frames plus hand sequences for glitch, framing, overrun, reset.
module tb_print_status_rx;

   localparam int B = 19;
   localparam int H = B / 2;
   localparam int P = B + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       data_ready;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   always #5 clk = ~clk;

   print_status_rx #(.BAUD_NUM(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data_ready (data_ready),
      .data       (data),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   int n_run  = 0;
   int n_fail = 0;

   int         got_n = 0;
   int         vcyc  = 0;
   int         fe_n  = 0;
   int         ov_n  = 0;
   logic [7:0] last_d = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid && data_ready) begin
            got_n  <= got_n + 1;
            last_d <= data;
         end
         if (data_valid) vcyc <= vcyc + 1;
         if (frame_err)  fe_n <= fe_n + 1;
         if (overrun)    ov_n <= ov_n + 1;
      end
   end

   logic [7:0] s_data;
   logic       s_valid;
   logic       s_busy;
   logic       s_fe;

   typedef struct {
      logic [7:0] tx;
      logic       stop;
      int         exp_n;
      logic [7:0] exp_d;
      int         exp_fe;
   } vec_t;

   vec_t vt[6];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) step();
   endtask

   task automatic send(input logic [7:0] b, input logic stop,
                       input bit glitch, input int rlo, input int rhi);
      for (int c = 0; c < 10 * P; c++) begin
         int   idx;
         logic v;
         idx = c / P;
         if (idx == 0)      v = 1'b0;
         else if (idx == 9) v = stop;
         else               v = b[idx-1];
         if (glitch && idx >= 1 && idx <= 8 && c == 1 + H + idx * P)
            v = ~v;
         rx  = v;
         rst = (c >= rlo && c < rhi);
         if (c == rhi - 1) begin
            s_data  = data;
            s_valid = data_valid;
            s_busy  = busy;
            s_fe    = frame_err;
         end
         step();
      end
      rst = 1'b0;
   endtask

   int         b_got, b_vc, b_fe, b_ov;
   logic [7:0] exp_maj;

   task automatic mark();
      b_got = got_n;
      b_vc  = vcyc;
      b_fe  = fe_n;
      b_ov  = ov_n;
   endtask

   initial begin
      vt[0] = '{8'h41, 1'b1, 1, 8'h41, 0};
      vt[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vt[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vt[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
      vt[4] = '{8'h01, 1'b1, 1, 8'h01, 0};
      vt[5] = '{8'h6E, 1'b0, 0, 8'h00, 1};

      rst        = 1'b1;
      rx         = 1'b1;
      data_ready = 1'b1;
      repeat (3) step();
      check("rst_data",  {24'h0, data}, 32'h0);
      check("rst_valid", {31'h0, data_valid}, 32'h0);
      check("rst_busy",  {31'h0, busy}, 32'h0);
      check("rst_fe",    {31'h0, frame_err}, 32'h0);
      check("rst_ov",    {31'h0, overrun}, 32'h0);
      rst = 1'b0;
      idle(5);

      for (int i = 0; i < 6; i++) begin
         mark();
         send(vt[i].tx, vt[i].stop, 1'b0, -1, -1);
         idle(2 * P);
         check($sformatf("vec%0d_count", i), got_n - b_got, vt[i].exp_n);
         check($sformatf("vec%0d_vcyc", i), vcyc - b_vc, vt[i].exp_n);
         check($sformatf("vec%0d_fe", i), fe_n - b_fe, vt[i].exp_fe);
         check($sformatf("vec%0d_ov", i), ov_n - b_ov, 0);
         check($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
         if (vt[i].exp_n != 0)
            check($sformatf("vec%0d_data", i), {24'h0, last_d},
                  {24'h0, vt[i].exp_d});
      end

      mark();
      rx = 1'b0;
      repeat (4) step();
      check("glitch_busy_hi", {31'h0, busy}, 32'h1);
      idle(2 * P);
      check("glitch_busy_lo", {31'h0, busy}, 32'h0);
      check("glitch_nodata", got_n - b_got, 0);
      check("glitch_novalid", vcyc - b_vc, 0);
      mark();
      send(8'h5A, 1'b1, 1'b0, -1, -1);
      idle(2 * P);
      check("after_glitch_n", got_n - b_got, 1);
      check("after_glitch_d", {24'h0, last_d}, 32'h5A);

      mark();
      send(8'hC3, 1'b0, 1'b0, -1, -1);
      rx = 1'b0;
      repeat (3 * P) step();
      check("ferr_pulse", fe_n - b_fe, 1);
      check("ferr_nodata", got_n - b_got, 0);
      check("ferr_busy_low", {31'h0, busy}, 32'h1);
      idle(4);
      check("ferr_busy_rel", {31'h0, busy}, 32'h0);
      mark();
      send(8'h11, 1'b1, 1'b0, -1, -1);
      idle(2 * P);
      check("after_ferr_n", got_n - b_got, 1);
      check("after_ferr_d", {24'h0, last_d}, 32'h11);

      mark();
      data_ready = 1'b0;
      send(8'h12, 1'b1, 1'b0, -1, -1);
      send(8'h34, 1'b1, 1'b0, -1, -1);
      idle(2 * P);
      check("ovr_data", {24'h0, data}, 32'h12);
      check("ovr_valid", {31'h0, data_valid}, 32'h1);
      check("ovr_pulse", ov_n - b_ov, 1);
      check("ovr_noconsume", got_n - b_got, 0);
      data_ready = 1'b1;
      step();
      check("ovr_drop", {31'h0, data_valid}, 32'h0);
      step();
      check("ovr_consumed_n", got_n - b_got, 1);
      check("ovr_consumed_d", {24'h0, last_d}, 32'h12);

      mark();
      send(8'hEF, 1'b1, 1'b0, 5 * P + 2, 5 * P + 16);
      check("mrst_data", {24'h0, s_data}, 32'h0);
      check("mrst_valid", {31'h0, s_valid}, 32'h0);
      check("mrst_busy", {31'h0, s_busy}, 32'h0);
      check("mrst_fe", {31'h0, s_fe}, 32'h0);
      idle(2 * P);
      check("mrst_nodata", got_n - b_got, 0);
      check("mrst_idle", {31'h0, busy}, 32'h0);
      mark();
      send(8'hFF, 1'b1, 1'b0, -1, -1);
      idle(2 * P);
      check("after_mrst_n", got_n - b_got, 1);
      check("after_mrst_d", {24'h0, last_d}, 32'hFF);

`ifdef PRINT_RX_MAJORITY_EN
      exp_maj = 8'hA5;
`else
      exp_maj = 8'h5A;
`endif
      mark();
      send(8'hA5, 1'b1, 1'b1, -1, -1);
      idle(2 * P);
      check("maj_n", got_n - b_got, 1);
      check("maj_d", {24'h0, last_d}, {24'h0, exp_maj});

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
